// File: rtl/mac_feeder_if.sv
// Bus between the feeder and its MAC PE plus the downstream psum port.
// psum handshake: a result moves only on a rising edge where psum_valid && psum_ready;
// while valid is high and ready is low, psum_valid and psum_data hold steady.
interface mac_feeder_if #(
  parameter int DATA_BITWIDTH = 8,
  parameter int PSUM_W        = 32
) ();
  logic                     en_MAC_din;
  logic                     en_MAC_dout;
  logic [DATA_BITWIDTH-1:0] iact;
  logic [DATA_BITWIDTH-1:0] wght;
  logic [PSUM_W-1:0]        mac_dout;
  logic                     psum_valid;
  logic                     psum_ready;
  logic [PSUM_W-1:0]        psum_data;

  modport master (
    output en_MAC_din, en_MAC_dout, iact, wght, psum_valid, psum_data,
    input  mac_dout, psum_ready
  );

  modport slave (
    input  en_MAC_din, en_MAC_dout, iact, wght, psum_valid, psum_data,
    output mac_dout, psum_ready
  );
endinterface

// File: rtl/mac_feeder.sv
// Streams one kernel from local scratchpads into a pipelined MAC, flushes it,
// captures the accumulated result and offers it on a valid/ready port.
module mac_feeder #(
  parameter int DATA_BITWIDTH = 8,
  parameter int KERNEL_SIZE   = 49,
  parameter int ADDR_W        = 6,
  parameter int PSUM_W        = 32
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     ld_iact_we,
  input  logic                     ld_wght_we,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_BITWIDTH-1:0] ld_data,
  input  logic                     start,
  output logic                     busy,
  output logic [2:0]               dbg_state,
  mac_feeder_if.master             bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STREAM  = 3'd1,
    S_FLUSH   = 3'd2,
    S_WAIT    = 3'd3,
    S_CAPTURE = 3'd4,
    S_OUTPUT  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(KERNEL_SIZE - 1);

  state_t                   state, state_next;
  logic [ADDR_W-1:0]        k, k_next;
  logic [DATA_BITWIDTH-1:0] iact_spad [KERNEL_SIZE];
  logic [DATA_BITWIDTH-1:0] wght_spad [KERNEL_SIZE];
  logic                     addr_ok;
  logic                     din_n, dout_n;
  logic [DATA_BITWIDTH-1:0] iact_n, wght_n;

  assign addr_ok   = {1'b0, ld_addr} < (ADDR_W + 1)'(KERNEL_SIZE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Scratchpads hold data across reset; loads only land while idle.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && addr_ok) begin
      if (ld_iact_we) iact_spad[ld_addr] <= ld_data;
      if (ld_wght_we) wght_spad[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= S_IDLE;
      k     <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
    end
  end

  always_comb begin
    state_next = state;
    k_next     = k;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_STREAM;
          k_next     = '0;
        end
      end
      S_STREAM: begin
        if (k == K_LAST) state_next = S_FLUSH;
        else             k_next     = k + ADDR_W'(1);
      end
      S_FLUSH:   state_next = S_WAIT;
      S_WAIT:    state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_OUTPUT;
      S_OUTPUT: begin
        if (bus.psum_valid && bus.psum_ready) state_next = S_IDLE;
      end
      default:   state_next = S_IDLE;
    endcase
  end

  // MAC-side values are decoded from the upcoming state so they can be
  // registered and still line up with the state they belong to.
  always_comb begin
    din_n  = 1'b0;
    dout_n = 1'b0;
    iact_n = '0;
    wght_n = '0;
    case (state_next)
      S_STREAM: begin
        din_n  = 1'b1;
        iact_n = iact_spad[k_next];
        wght_n = wght_spad[k_next];
      end
      S_FLUSH: begin
        din_n  = 1'b1;
        dout_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bus.en_MAC_din  <= 1'b0;
      bus.en_MAC_dout <= 1'b0;
      bus.iact        <= '0;
      bus.wght        <= '0;
    end else begin
      bus.en_MAC_din  <= din_n;
      bus.en_MAC_dout <= dout_n;
      bus.iact        <= iact_n;
      bus.wght        <= wght_n;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      bus.psum_valid <= 1'b0;
      bus.psum_data  <= '0;
    end else if (state == S_CAPTURE) begin
      bus.psum_valid <= 1'b1;
      bus.psum_data  <= bus.mac_dout;
    end else if (bus.psum_valid && bus.psum_ready) begin
      bus.psum_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Directed bench for mac_feeder with a behavioural pipelined MAC PE as responder.
module tb_mac_feeder;

  logic       clk = 1'b0;
  logic       rstN;
  logic       ld_iact_we, ld_wght_we;
  logic [5:0] ld_addr;
  logic [7:0] ld_data;
  logic       start;
  logic       busy;
  logic [2:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  mac_feeder_if bus ();

  mac_feeder dut (
    .clk        (clk),
    .rstN       (rstN),
    .ld_iact_we (ld_iact_we),
    .ld_wght_we (ld_wght_we),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .start      (start),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Responder MAC: operand registers, product accumulated on the next enable,
  // dump one cycle after the dout request, then psum cleared.
  logic [7:0]  op_a, op_w;
  logic [31:0] psum_acc, mac_dout_r, prod;
  logic        dump_r;

  assign prod         = $signed({24'b0, op_a}) * $signed({{24{op_w[7]}}, op_w});
  assign bus.mac_dout = mac_dout_r;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      op_a       <= '0;
      op_w       <= '0;
      psum_acc   <= '0;
      mac_dout_r <= '0;
      dump_r     <= 1'b0;
    end else begin
      if (bus.en_MAC_din) begin
        op_a     <= bus.iact;
        op_w     <= bus.wght;
        psum_acc <= psum_acc + prod;
      end
      dump_r <= bus.en_MAC_dout;
      if (dump_r) begin
        mac_dout_r <= psum_acc;
        psum_acc   <= '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind 0: constant val everywhere; kind 1: element k gets value k.
  task automatic load_spad(input bit wi, input bit ww, input int kind, input logic [7:0] val);
    for (int k = 0; k < 49; k++) begin
      @(negedge clk);
      ld_iact_we = wi;
      ld_wght_we = ww;
      ld_addr    = 6'(k);
      ld_data    = (kind == 1) ? 8'(k) : val;
    end
    @(negedge clk);
    ld_iact_we = 1'b0;
    ld_wght_we = 1'b0;
  endtask

  task automatic run_pass(input string tag, input logic [31:0] exp, input int hold,
                          input logic [7:0] a0, input logic [7:0] w0);
    int din_cnt, dout_cnt, early_valid;
    din_cnt = 0; dout_cnt = 0; early_valid = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 53; n++) begin
      if (n > 1) @(negedge clk);
      if (bus.en_MAC_din)  din_cnt++;
      if (bus.en_MAC_dout) dout_cnt++;
      if (n < 53 && bus.psum_valid) early_valid++;
      if (n == 1) begin
        chk({tag, "_iact0"}, 32'(bus.iact), 32'(a0));
        chk({tag, "_wght0"}, 32'(bus.wght), 32'(w0));
      end
      if (n == 50) begin
        chk({tag, "_flush_dout"}, 32'(bus.en_MAC_dout), 32'd1);
        chk({tag, "_flush_zero"}, {16'b0, bus.iact, bus.wght}, 32'd0);
      end
    end
    chk({tag, "_din_cnt"}, 32'(din_cnt), 32'd50);
    chk({tag, "_dout_cnt"}, 32'(dout_cnt), 32'd1);
    chk({tag, "_early_valid"}, 32'(early_valid), 32'd0);
    chk({tag, "_valid"}, 32'(bus.psum_valid), 32'd1);
    chk({tag, "_data"}, bus.psum_data, exp);
    for (int h = 0; h < hold; h++) begin
      bus.psum_ready = 1'b0;
      start      = (h == 3);
      ld_iact_we = (h == 5);
      ld_addr    = 6'd0;
      ld_data    = 8'h55;
      @(negedge clk);
      chk({tag, "_hold_valid"}, 32'(bus.psum_valid), 32'd1);
      chk({tag, "_hold_data"}, bus.psum_data, exp);
      chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
      chk({tag, "_hold_state"}, 32'(dbg_state), 32'd5);
      chk({tag, "_hold_din"}, 32'(bus.en_MAC_din), 32'd0);
    end
    start      = 1'b0;
    ld_iact_we = 1'b0;
    bus.psum_ready = 1'b1;
    @(negedge clk);
    bus.psum_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.psum_valid), 32'd0);
    chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_no_queued_start"}, {30'b0, busy, bus.en_MAC_din}, 32'd0);
  endtask

  initial begin
    int valid_seen;
    rstN = 1'b0;
    ld_iact_we = 1'b0; ld_wght_we = 1'b0;
    ld_addr = '0; ld_data = '0; start = 1'b0;
    bus.psum_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mac", {bus.en_MAC_din, bus.en_MAC_dout, 14'b0, bus.iact, bus.wght}, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(bus.psum_valid), 32'd0);
    chk("rst_data", bus.psum_data, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rstN = 1'b1;

    load_spad(1'b1, 1'b0, 0, 8'd1);
    load_spad(1'b0, 1'b1, 0, 8'd2);
    run_pass("ones_twos", 32'd98, 0, 8'd1, 8'd2);

    load_spad(1'b1, 1'b0, 0, 8'd3);
    load_spad(1'b0, 1'b1, 0, 8'hFF);
    run_pass("neg_hold", 32'hFFFF_FF6D, 10, 8'd3, 8'hFF);
    run_pass("neg_again", 32'hFFFF_FF6D, 0, 8'd3, 8'hFF);

    load_spad(1'b1, 1'b0, 0, 8'hFF);
    load_spad(1'b0, 1'b1, 0, 8'd1);
    run_pass("unsigned_act", 32'd12495, 0, 8'hFF, 8'd1);
    @(negedge clk);
    ld_iact_we = 1'b1; ld_wght_we = 1'b1; ld_addr = 6'd50; ld_data = 8'h7F;
    @(negedge clk);
    ld_iact_we = 1'b0; ld_wght_we = 1'b0;
    run_pass("oob_write", 32'd12495, 0, 8'hFF, 8'd1);

    load_spad(1'b1, 1'b0, 1, 8'd0);
    load_spad(1'b0, 1'b1, 0, 8'd1);
    run_pass("ramp_a", 32'd1176, 0, 8'd0, 8'd1);
    run_pass("ramp_b", 32'd1176, 0, 8'd0, 8'd1);

    // Abort in the middle of streaming.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_abort_din", 32'(bus.en_MAC_din), 32'd1);
    rstN = 1'b0;
    #1;
    chk("abort_mac", {bus.en_MAC_din, bus.en_MAC_dout, 14'b0, bus.iact, bus.wght}, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(bus.psum_valid), 32'd0);
    chk("abort_data", bus.psum_data, 32'd0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    valid_seen = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.psum_valid || busy) valid_seen++;
    end
    chk("abort_no_result", 32'(valid_seen), 32'd0);
    load_spad(1'b1, 1'b1, 0, 8'd2);
    run_pass("after_abort", 32'd196, 0, 8'd2, 8'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
